vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_scanout_if.sv | 11 +
 rtl/vga_timing.sv | 70 +++++++
 rtl/vga_scanout.sv | 117 +++++++++++
 tb/tb_vga_scanout.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing for the scanout block.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 32'd640;
  localparam int unsigned VGA_H_FP     = 32'd16;
  localparam int unsigned VGA_H_SYNC   = 32'd96;
  localparam int unsigned VGA_H_BP     = 32'd48;
  localparam int unsigned VGA_V_ACTIVE = 32'd480;
  localparam int unsigned VGA_V_FP     = 32'd10;
  localparam int unsigned VGA_V_SYNC   = 32'd2;
  localparam int unsigned VGA_V_BP     = 32'd33;

  localparam int unsigned VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam logic        VGA_SYNC_ACTIVE = 1'b0;
  localparam int unsigned VGA_PIPE_LAT    = 32'd2;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
  } pix_addr_t;

  typedef logic [7:0] rgb332_t;

  // Per-pixel control bits travelling alongside the address through the pipeline.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic sof;
  } ctl_t;

  localparam ctl_t      CTL_IDLE      = '{active: 1'b0, hs: 1'b0, vs: 1'b0, sof: 1'b0};
  localparam pix_addr_t PIX_ADDR_ZERO = '{y: 10'd0, x: 10'd0};

  function automatic logic in_window(input logic [9:0] cnt, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  function automatic logic sync_pin(input logic asserted, input logic level);
    return asserted ? level : ~level;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Scanout <-> gpu controller bus: pixel address and mode out, pixel colour back.
interface vga_scanout_if;

  vga_pkg::pix_addr_t address;
  logic               mode;
  vga_pkg::rgb332_t   pixel_in;

  modport master (output address, output mode, input pixel_in);
  modport slave  (input address, input mode, output pixel_in);

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and combinational decode of the current position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce_i,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output ctl_t       ctl_o
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 32'd1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 32'd1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Next raster position: h wraps at end of line and carries into v.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else if (pix_ce_i) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    ctl_o.active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    ctl_o.hs     = in_window(h_cnt_q, H_SS, H_SE);
    ctl_o.vs     = in_window(v_cnt_q, V_SS, V_SE);
    ctl_o.sof    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_scanout.sv
// Raster scanout: issues pixel addresses to the gpu, then re-aligns returned colour
// with sync/blank so every DAC pin lags the counters by PIPE_LAT+1 ticks.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter logic        SYNC_ACTIVE = VGA_SYNC_ACTIVE,
  parameter int unsigned PIPE_LAT    = VGA_PIPE_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          mode_req,
  vga_scanout_if.master gpu,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output rgb332_t       rgb,
  output logic          frame_start
);

  logic [9:0] h_cnt_s, v_cnt_s;
  ctl_t       ctl_s;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_ce_i (pix_ce),
    .h_cnt_o  (h_cnt_s),
    .v_cnt_o  (v_cnt_s),
    .ctl_o    (ctl_s)
  );

  ctl_t      ctl0_q;
  pix_addr_t address_q;
  logic      mode_q;
  ctl_t      dl_q [PIPE_LAT];
  ctl_t      tail_s;

  logic      hsync_q, vsync_q, video_on_q, frame_start_q;
  rgb332_t   rgb_q;

  // Stage 0: address to the gpu; mode is latched only at the top-left pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl0_q    <= CTL_IDLE;
      address_q <= PIX_ADDR_ZERO;
      mode_q    <= 1'b0;
    end else if (pix_ce) begin
      ctl0_q    <= ctl_s;
      address_q <= ctl_s.active ? '{y: v_cnt_s, x: h_cnt_s} : PIX_ADDR_ZERO;
      if (ctl_s.sof) begin
        mode_q <= mode_req;
      end
    end
  end

  // Control bits wait here while the gpu fetches the pixel for the same position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        dl_q[i] <= CTL_IDLE;
      end
    end else if (pix_ce) begin
      dl_q[0] <= ctl0_q;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign tail_s = dl_q[PIPE_LAT-1];

  // Output stage; frame_start drops on the next clk so it lasts one clk, not one tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else if (pix_ce) begin
      hsync_q       <= sync_pin(tail_s.hs, SYNC_ACTIVE);
      vsync_q       <= sync_pin(tail_s.vs, SYNC_ACTIVE);
      video_on_q    <= tail_s.active;
      rgb_q         <= tail_s.active ? gpu.pixel_in : 8'h00;
      frame_start_q <= tail_s.sof;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign gpu.address = address_q;
  assign gpu.mode    = mode_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: full-width lines, shortened frame height.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 8,   VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 3;

  typedef struct packed {
    logic [19:0] addr;
    logic        mode;
    logic        hs;
    logic        vs;
    logic        von;
    logic [7:0]  rgb;
    logic        fs;
  } obs_t;

  localparam obs_t OBS_RST = '{addr: 20'h0, mode: 1'b0, hs: 1'b1, vs: 1'b1,
                               von: 1'b0, rgb: 8'h00, fs: 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst_n, pix_ce, mode_req;
  logic    hsync, vsync, video_on, frame_start;
  rgb332_t rgb;

  vga_scanout_if gpu_bus();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .PIPE_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .mode_req(mode_req),
    .gpu(gpu_bus),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
    .frame_start(frame_start)
  );

  // Downstream path: returns address[7:0] two ticks later.
  logic [7:0] gpu_p0, gpu_p1;
  always @(posedge clk) begin
    if (!rst_n) begin
      gpu_p0 <= 8'h00;
      gpu_p1 <= 8'h00;
    end else if (pix_ce) begin
      gpu_p0 <= gpu_bus.address[7:0];
      gpu_p1 <= gpu_p0;
    end
  end
  assign gpu_bus.pixel_in = gpu_p1;

  obs_t exp_q[$];
  obs_t cur;
  int   pos;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ce_const = 1'b0;

  // Expected pins after one clock edge, from raster position arithmetic.
  task automatic step(input logic r, input logic ce, input logic mr);
    int q, h, v, ph, pv;
    rst_n    = r;
    pix_ce   = ce;
    mode_req = mr;
    if (!r) begin
      cur = OBS_RST;
      pos = 0;
    end else if (ce) begin
      ph = pos % HT;
      pv = (pos / HT) % VT;
      cur.addr = (ph < HA && pv < VA) ? {10'(pv), 10'(ph)} : 20'h0;
      if (pos % FRAME == 0) cur.mode = mr;
      q = pos - LAT;
      if (q < 0) begin
        cur.hs = 1'b1; cur.vs = 1'b1; cur.von = 1'b0; cur.rgb = 8'h00; cur.fs = 1'b0;
      end else begin
        h = q % HT;
        v = (q / HT) % VT;
        cur.von = (h < HA) && (v < VA);
        cur.hs  = !(h >= HA + HF && h < HA + HF + HS);
        cur.vs  = !(v >= VA + VF && v < VA + VF + VS);
        cur.rgb = cur.von ? 8'(h) : 8'h00;
        cur.fs  = (h == 0) && (v == 0);
      end
      pos++;
    end else begin
      cur.fs = 1'b0;
    end
    exp_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per clock and checks the pins mid-cycle.
  initial begin
    obs_t exp, act;
    longint cyc = 0;
    longint last_fs = -1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = '{addr: gpu_bus.address, mode: gpu_bus.mode, hs: hsync, vs: vsync,
                von: video_on, rgb: rgb, fs: frame_start};
        n_cmp++;
        if (act !== exp) begin
          n_err++;
          $display("FAIL pins t=%0t actual addr=%05h mode=%b hs=%b vs=%b von=%b rgb=%02h fs=%b required addr=%05h mode=%b hs=%b vs=%b von=%b rgb=%02h fs=%b",
                   $time, act.addr, act.mode, act.hs, act.vs, act.von, act.rgb, act.fs,
                   exp.addr, exp.mode, exp.hs, exp.vs, exp.von, exp.rgb, exp.fs);
        end
      end
      if (frame_start === 1'b1 && ce_const) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (cyc - last_fs != longint'(FRAME)) begin
            n_err++;
            $display("FAIL frame_period actual=%0d required=%0d", cyc - last_fs, FRAME);
          end
        end
        last_fs = cyc;
      end
    end
  end

  initial begin
    logic md, ce, r;
    rst_n = 1'b0; pix_ce = 1'b0; mode_req = 1'b0;
    cur = OBS_RST;
    pos = 0;

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);

    // Continuous ticks; mode_req rises at line 5 and must wait for the next frame.
    ce_const = 1'b1;
    for (int i = 0; i < FRAME + 200; i++) step(1'b1, 1'b1, (i >= 5 * HT) ? 1'b1 : 1'b0);
    ce_const = 1'b0;

    // One tick every 4th clock, then reset in the middle of line 3.
    for (int c = 0; c < 4 * FRAME && (pos % FRAME) != (3 * HT + HA / 2); c++)
      step(1'b1, (c % 4) == 3, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 4 * 1000; c++) step(1'b1, (c % 4) == 3, 1'b0);

    // Random tick pattern and mode requests, long enough to cross a frame boundary.
    md = 1'b0;
    for (int c = 0; c < 26000; c++) begin
      ce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) md = ~md;
      r = ($urandom_range(0, 7999) != 0);
      step(r, ce, md);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
